// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared types for the instruction sequencer and its decoder.
package instr_sequencer_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_cmd_t;
    typedef struct packed {
        logic dst_in_sel;
    } ctrl_sig_t;
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_INIT = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_JMP  = 4'h7,
        OP_HALT = 4'hF
    } opcode_t;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} seq_state_t;
endpackage

// File: rtl/instr_sequencer_decoder.sv
// instr_decoder: combinational opcode -> DataPath control decode.
module instr_decoder
    import instr_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       reg_wr_en,
    output alu_cmd_t   alu_cmd,
    output ctrl_sig_t  ctrl_sig,
    output logic       illegal,
    output logic       is_jmp,
    output logic       is_halt
);
    always_comb begin
        reg_wr_en = 1'b0;
        alu_cmd   = ALU_ADD;
        ctrl_sig  = '0;
        illegal   = 1'b0;
        is_jmp    = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_INIT: begin
                reg_wr_en           = 1'b1;
                ctrl_sig.dst_in_sel = 1'b1;
            end
            OP_ADD:  reg_wr_en = 1'b1;
            OP_SUB:  begin reg_wr_en = 1'b1; alu_cmd = ALU_SUB; end
            OP_AND:  begin reg_wr_en = 1'b1; alu_cmd = ALU_AND; end
            OP_OR:   begin reg_wr_en = 1'b1; alu_cmd = ALU_OR;  end
            OP_XOR:  begin reg_wr_en = 1'b1; alu_cmd = ALU_XOR; end
            OP_JMP:  is_jmp = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/exec control unit driving DataPath; owns PC and IR.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] BOOT_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [11:0]     operands,
    output logic            reg_wr_en,
    output alu_cmd_t        alu_cmd,
    output ctrl_sig_t       ctrl_sig,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);
    seq_state_t state;
    logic [15:0] ir;
    logic        exec;
    logic        dec_wr;
    alu_cmd_t    dec_alu;
    ctrl_sig_t   dec_ctrl;
    logic        dec_ill;
    logic        dec_jmp;
    logic        dec_halt;

    instr_decoder u_dec (
        .opcode    (ir[15:12]),
        .reg_wr_en (dec_wr),
        .alu_cmd   (dec_alu),
        .ctrl_sig  (dec_ctrl),
        .illegal   (dec_ill),
        .is_jmp    (dec_jmp),
        .is_halt   (dec_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= BOOT_ADDR;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: if (start) begin
                    state   <= FETCH;
                    pc      <= BOOT_ADDR;
                    illegal <= 1'b0;
                end
                FETCH: if (imem_ack) begin
                    state <= EXEC;
                    ir    <= imem_rdata;
                end
                default: begin
                    state   <= dec_halt ? HALT : FETCH;
                    // jump target is truncated or zero-extended to the PC width
                    pc      <= dec_jmp ? PC_W'(ir[11:0]) : dec_halt ? pc : pc + 1'b1;
                    illegal <= illegal | dec_ill;
                end
            endcase
        end
    end

    assign exec      = state == EXEC;
    assign imem_req  = state == FETCH;
    assign imem_addr = pc;
    assign operands  = exec ? ir[11:0] : '0;
    assign reg_wr_en = exec & dec_wr;
    assign alu_cmd   = exec ? dec_alu : ALU_ADD;
    assign ctrl_sig  = exec ? dec_ctrl : '0;
    assign busy      = imem_req | exec;
    assign halted    = state == HALT;
endmodule
